// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK frame transmit/receive path: line levels,
// the checked-word width and the frame state encoding.
package fsk_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } fsk_state_e;

  // Line levels as seen by the modulator.
  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  // Width of the checked word (8 data bits + 1 check bit).
  localparam int unsigned CHK_W = 9;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter shared by the transmit and receive paths.
// Both ticks are look-ahead decodes of the counter's next value, so a
// consumer can register them and see them aligned with the bit they describe:
//   tick_start - the next clock is the first clock of a bit (count 0)
//   tick_last  - the next clock is the last clock of a bit (count BIT_CYCLES-1)
module bit_timer
  import fsk_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick_start,
  output logic tick_last
);

  localparam int unsigned CNT_W = cnt_width(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: forced to zero on restart, otherwise wraps at BIT_CYCLES-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_start = (cnt_d == '0);
  assign tick_last  = (cnt_d == CNT_LAST);

endmodule

// File: rtl/fsk_frame_tx.sv
// Bit-serial frame transmitter: start bit, DATA_W word bits LSB first, then
// STOP_BITS stop bits, each held BIT_CYCLES clocks. All outputs are flops
// loaded from the decoded next state, so they line up with the bit on the line.
module fsk_frame_tx
  import fsk_pkg::*;
#(
  parameter int unsigned DATA_W     = CHK_W,
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_STOP  = ST_STOP;

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam int unsigned SB_W  = cnt_width(STOP_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [SB_W-1:0]  SB_LAST  = SB_W'(STOP_BITS - 1);
  // With one clock per bit the counter sits on its last value from reset.
  localparam logic LAST_AT_RESET = (BIT_CYCLES == 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SB_W-1:0]   stop_q, stop_d;
  logic              last_q;
  logic              bit_out_q, bit_out_d;
  logic              bit_strobe_q, bit_strobe_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              din_ready_q, din_ready_d;

  logic handshake;
  logic bit_end;
  logic timer_en;
  logic timer_restart;
  logic tick_start;
  logic tick_last;

  assign handshake     = din_valid && din_ready_q;
  assign timer_en      = (state_q != S_IDLE);
  assign timer_restart = (state_q == S_IDLE) && handshake;
  // Current clock is the final clock of the bit being sent.
  assign bit_end       = last_q && (state_q != S_IDLE);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (timer_restart),
    .en        (timer_en),
    .tick_start(tick_start),
    .tick_last (tick_last)
  );

  // Frame sequencing: word capture, data shifting, bit and stop-bit counting.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          shreg_d = din;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            stop_d  = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == SB_LAST) begin
            stop_d = '0;
            if (handshake) begin
              // Back-to-back: next start bit follows the last stop clock directly.
              shreg_d = din;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + SB_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output can be a plain flop.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    bit_strobe_d = busy_d && tick_start;
    frame_done_d = (state_d == S_STOP) && (stop_d == SB_LAST) && tick_last;
    din_ready_d  = !busy_d || frame_done_d;
    case (state_d)
      S_START: bit_out_d = SPACE;
      S_DATA:  bit_out_d = shreg_d[0];
      default: bit_out_d = MARK;
    endcase
  end

  // State, datapath and output registers; reset parks the line at mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      stop_q       <= '0;
      last_q       <= LAST_AT_RESET;
      bit_out_q    <= MARK;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      stop_q       <= stop_d;
      last_q       <= tick_last;
      bit_out_q    <= bit_out_d;
      bit_strobe_q <= bit_strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_strobe = bit_strobe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign din_ready  = din_ready_q;

endmodule
